// File: rtl/sr_flipflop_bank.sv
// Bank of WIDTH flip-flops with run-time selectable SR/JK/D/T behaviour,
// sticky illegal-SR flags, a registered change pulse and a saturating change counter.
module sr_flipflop_bank #(
  parameter int              WIDTH = 8,
  parameter int              CNT_W = 8,
  parameter logic [WIDTH-1:0] INIT = {WIDTH{1'b0}}
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             ERR_CLR,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar,
  output logic [WIDTH-1:0] ILLEGAL,
  output logic             CHANGED,
  output logic [CNT_W-1:0] CHG_CNT
);

  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_D  = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] ill_q, ill_d;
  logic [WIDTH-1:0] new_ill;
  logic             chg_q, chg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_moves;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    q_d     = q_q;
    new_ill = '0;
    if (EN) begin
      unique case (MODE)
        MODE_SR: begin
          q_d     = (q_q | (A & ~B)) & ~(B & ~A);
          new_ill = A & B;
        end
        MODE_JK: q_d = (A & ~q_q) | (~B & q_q);
        MODE_D:  q_d = A;
        MODE_T:  q_d = q_q ^ A;
        default: q_d = q_q;
      endcase
    end
  end

  // Set wins over clear for a bit flagged on the same edge.
  assign ill_d   = (ERR_CLR ? '0 : ill_q) | new_ill;
  assign q_moves = (q_d != q_q);
  assign chg_d   = q_moves;
  assign cnt_d   = (q_moves && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (RST) begin
      q_q   <= INIT;
      ill_q <= '0;
      chg_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      ill_q <= ill_d;
      chg_q <= chg_d;
      cnt_q <= cnt_d;
    end
  end

  assign Q       = q_q;
  assign Qbar    = ~q_q;
  assign ILLEGAL = ill_q;
  assign CHANGED = chg_q;
  assign CHG_CNT = cnt_q;

endmodule

// File: tb/tb_sr_flipflop_bank.sv
// Randomised and directed bench for sr_flipflop_bank against a per-bit behavioural model;
// a second instance with a 2-bit counter shares the inputs to exercise saturation.
module tb_sr_flipflop_bank;

  localparam int         WIDTH = 4;
  localparam logic [3:0] INIT  = 4'b0000;

  logic       clk = 1'b0;
  logic       rst, en, err_clr;
  logic [1:0] mode;
  logic [3:0] a, b;

  logic [3:0] q, qbar, ill;
  logic       changed;
  logic [7:0] cnt;
  logic [3:0] q_s, qbar_s, ill_s;
  logic       changed_s;
  logic [1:0] cnt_s;

  int checks = 0;
  int passes = 0;

  // Reference model state
  logic [3:0] m_q, m_ill;
  logic       m_chg;
  int         m_cnt, m_cnt_s;

  always #5 clk = ~clk;

  sr_flipflop_bank #(.WIDTH(WIDTH), .CNT_W(8), .INIT(INIT)) dut (
    .CLK(clk), .RST(rst), .EN(en), .MODE(mode), .A(a), .B(b), .ERR_CLR(err_clr),
    .Q(q), .Qbar(qbar), .ILLEGAL(ill), .CHANGED(changed), .CHG_CNT(cnt)
  );

  sr_flipflop_bank #(.WIDTH(WIDTH), .CNT_W(2), .INIT(INIT)) dut_s (
    .CLK(clk), .RST(rst), .EN(en), .MODE(mode), .A(a), .B(b), .ERR_CLR(err_clr),
    .Q(q_s), .Qbar(qbar_s), .ILLEGAL(ill_s), .CHANGED(changed_s), .CHG_CNT(cnt_s)
  );

  function automatic logic [30:0] dut_vec();
    return {q, qbar, ill, changed, cnt, cnt_s, q_s ^ q, ill_s ^ ill};
  endfunction

  function automatic logic [30:0] exp_vec();
    return {m_q, ~m_q, m_ill, m_chg, 8'(m_cnt), 2'(m_cnt_s), 4'b0000, 4'b0000};
  endfunction

  // Apply the behavioural rules to the model for one rising edge.
  task automatic model_edge();
    logic [3:0] nq, nill;
    if (rst) begin
      m_q = INIT; m_ill = '0; m_chg = 1'b0; m_cnt = 0; m_cnt_s = 0;
      return;
    end
    nq   = m_q;
    nill = '0;
    if (en) begin
      for (int i = 0; i < WIDTH; i++) begin
        case (mode)
          2'd0: begin
            if (a[i] && !b[i])      nq[i] = 1'b1;
            else if (!a[i] && b[i]) nq[i] = 1'b0;
            else if (a[i] && b[i])  nill[i] = 1'b1;
          end
          2'd1: begin
            if (a[i] && b[i]) nq[i] = !m_q[i];
            else if (a[i])    nq[i] = 1'b1;
            else if (b[i])    nq[i] = 1'b0;
          end
          2'd2: nq[i] = a[i];
          default: if (a[i]) nq[i] = !m_q[i];
        endcase
      end
    end
    m_ill = (err_clr ? 4'b0000 : m_ill) | nill;
    m_chg = (nq != m_q);
    if (m_chg) begin
      m_cnt   = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
      m_cnt_s = (m_cnt_s + 1 > 3) ? 3 : m_cnt_s + 1;
    end
    m_q = nq;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; mode = 2'b11; a = 4'hF; b = 4'hF; err_clr = 1'b0;
    m_q = 4'bxxxx; m_ill = 4'bxxxx; m_chg = 1'bx; m_cnt = 0; m_cnt_s = 0;
    tick(); tick();
    rst = 1'b0;
    checks++; if (dut_vec() !== exp_vec()) $display("FAIL reset_vec got=%h exp=%h", dut_vec(), exp_vec()); else passes++;
    checks++; if (q !== 4'b0000) $display("FAIL reset_q got=%b exp=0000", q); else passes++;
    checks++; if (qbar !== 4'b1111) $display("FAIL reset_qbar got=%b exp=1111", qbar); else passes++;
    checks++; if ({ill, changed, cnt} !== 13'd0) $display("FAIL reset_flags got=%b/%b/%0d exp=0", ill, changed, cnt); else passes++;
  endtask

  task automatic test_sr();
    mode = 2'b00; a = 4'b0101; b = 4'b0000; tick();
    checks++; if ({q, changed, cnt} !== {4'b0101, 1'b1, 8'd1}) $display("FAIL sr_set got=%b/%b/%0d exp=0101/1/1", q, changed, cnt); else passes++;
    a = 4'b0000; b = 4'b0001; tick();
    checks++; if ({q, cnt} !== {4'b0100, 8'd2}) $display("FAIL sr_clr got=%b/%0d exp=0100/2", q, cnt); else passes++;
    a = 4'b0000; b = 4'b0000; tick();
    checks++; if ({q, changed, cnt} !== {4'b0100, 1'b0, 8'd2}) $display("FAIL sr_hold got=%b/%b/%0d exp=0100/0/2", q, changed, cnt); else passes++;
    checks++; if (dut_vec() !== exp_vec()) $display("FAIL sr_vec got=%h exp=%h", dut_vec(), exp_vec()); else passes++;
  endtask

  task automatic test_sr_illegal();
    a = 4'b1001; b = 4'b1000; tick();
    checks++; if ({q, ill} !== {4'b0101, 4'b1000}) $display("FAIL ill_set got=%b/%b exp=0101/1000", q, ill); else passes++;
    err_clr = 1'b1; a = 4'b1000; b = 4'b1000; tick();
    checks++; if (ill !== 4'b1000) $display("FAIL ill_set_wins got=%b exp=1000", ill); else passes++;
    a = 4'b0000; b = 4'b0000; tick();
    checks++; if (ill !== 4'b0000) $display("FAIL ill_clear got=%b exp=0000", ill); else passes++;
    err_clr = 1'b0;
    checks++; if (dut_vec() !== exp_vec()) $display("FAIL ill_vec got=%h exp=%h", dut_vec(), exp_vec()); else passes++;
  endtask

  task automatic test_jk_t_d();
    mode = 2'b01; a = 4'hF; b = 4'hF; tick();
    checks++; if ({q, ill} !== {4'b1010, 4'b0000}) $display("FAIL jk_toggle got=%b/%b exp=1010/0000", q, ill); else passes++;
    mode = 2'b11; a = 4'b0011; tick();
    checks++; if (q !== 4'b1001) $display("FAIL t_toggle got=%b exp=1001", q); else passes++;
    mode = 2'b10; a = 4'b0110; b = 4'bxxxx; tick();
    checks++; if (q !== 4'b0110) $display("FAIL d_load got=%b exp=0110", q); else passes++;
    b = 4'b0000;
    checks++; if (dut_vec() !== exp_vec()) $display("FAIL jtd_vec got=%h exp=%h", dut_vec(), exp_vec()); else passes++;
  endtask

  task automatic test_enable();
    logic [7:0] cnt_before;
    cnt_before = cnt;
    en = 1'b0; mode = 2'b10; a = 4'hF;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({q, changed, cnt} !== {4'b0110, 1'b0, cnt_before}) $display("FAIL en_hold%0d got=%b/%b/%0d exp=0110/0/%0d", i, q, changed, cnt, cnt_before); else passes++;
    end
    mode = 2'b00; b = 4'hF; tick();
    checks++; if ({q, ill} !== {4'b0110, 4'b0000}) $display("FAIL en_no_ill got=%b/%b exp=0110/0000", q, ill); else passes++;
    en = 1'b1; mode = 2'b10; b = 4'h0; tick();
    checks++; if ({q, changed} !== {4'b1111, 1'b1}) $display("FAIL en_resume got=%b/%b exp=1111/1", q, changed); else passes++;
  endtask

  task automatic test_saturation();
    int exp_s [6] = '{1, 2, 3, 3, 3, 3};
    rst = 1'b1; tick(); rst = 1'b0;
    mode = 2'b11; a = 4'b0001; en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (cnt_s !== 2'(exp_s[i])) $display("FAIL sat_cnt%0d got=%0d exp=%0d", i, cnt_s, exp_s[i]); else passes++;
    end
    rst = 1'b1; tick();
    checks++; if ({cnt_s, cnt, q_s, q} !== {2'd0, 8'd0, INIT, INIT}) $display("FAIL sat_rst got=%0d/%0d/%b exp=0/0/%b", cnt_s, cnt, q, INIT); else passes++;
    rst = 1'b0; tick(); tick();
    checks++; if (dut_vec() !== exp_vec()) $display("FAIL sat_vec got=%h exp=%h", dut_vec(), exp_vec()); else passes++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst     = ($urandom_range(0, 49) == 0);
      en      = ($urandom_range(0, 4) != 0);
      err_clr = ($urandom_range(0, 7) == 0);
      mode    = 2'($urandom_range(0, 3));
      a       = 4'($urandom);
      b       = 4'($urandom);
      tick();
      checks++; if (dut_vec() !== exp_vec()) $display("FAIL rand%0d got=%h exp=%h", i, dut_vec(), exp_vec()); else passes++;
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sr();
    test_sr_illegal();
    test_jk_t_d();
    test_enable();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
